// File: rtl/ifu_fetch_stage.sv
`timescale 1ns/1ps
// Purpose  : instruction fetch stage; owns the PC, issues one AXI-Lite read per instruction to the I-cache,
//            buffers the returned word in a one-entry output buffer, and handles redirects and fetch faults.
// Latency  : address handshake in REQ, data accepted in WAIT_R, inst_valid in OUT (one request outstanding).
// Backpress: the OUT buffer holds inst/inst_pc/inst_fault stable until inst_ready; no new fetch until then.
// Ports    : clk/rst (sync, active-high); ic_ar*/ic_r* cache read channels; fence_i -> ic_fence_i passthrough;
//            redirect_valid/redirect_pc from branch/trap logic; inst_valid/inst_ready/inst/inst_pc/inst_fault to decode.
module ifu_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] ic_araddr,
    output logic        ic_arvalid,
    input  logic        ic_arready,
    input  logic [31:0] ic_rdata,
    input  logic [1:0]  ic_rresp,
    input  logic        ic_rvalid,
    output logic        ic_rready,
    input  logic        fence_i,
    output logic        ic_fence_i,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [1:0]  inst_fault
);

    typedef enum logic [1:0] {
        S_REQ    = 2'd0,
        S_WAIT_R = 2'd1,
        S_OUT    = 2'd2
    } state_t;

    localparam logic [1:0] FAULT_NONE   = 2'b00;
    localparam logic [1:0] FAULT_ACCESS = 2'b01;
    localparam logic [1:0] FAULT_MISAL  = 2'b10;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [1:0]  fault_q, fault_d;

    logic misaligned;
    logic ar_vld;

    assign misaligned = (pc_q[1:0] != 2'b00);
    // A misaligned PC never reaches the bus; the fault is synthesised locally.
    assign ar_vld     = (state_q == S_REQ) && !misaligned;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        kill_d    = kill_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        fault_d   = fault_q;

        case (state_q)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    // Old address already accepted: its response must be dropped.
                    if (ar_vld && ic_arready) begin
                        state_d = S_WAIT_R;
                        kill_d  = 1'b1;
                    end
                end else if (misaligned) begin
                    state_d   = S_OUT;
                    inst_d    = 32'h0;
                    inst_pc_d = pc_q;
                    fault_d   = FAULT_MISAL;
                end else if (ic_arready) begin
                    state_d = S_WAIT_R;
                end
            end

            S_WAIT_R: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    if (ic_rvalid) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end else if (ic_rvalid) begin
                    if (kill_q) begin
                        // Stale response; pc already holds the redirect target.
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        inst_d    = ic_rdata;
                        inst_pc_d = pc_q;
                        fault_d   = (ic_rresp != 2'b00) ? FAULT_ACCESS : FAULT_NONE;
                        state_d   = S_OUT;
                    end
                end
            end

            S_OUT: begin
                // Redirect beats a simultaneous inst_ready: the buffer is dropped, pc not incremented.
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = S_REQ;
                end else if (inst_ready) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_REQ;
                end
            end

            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            kill_q    <= 1'b0;
            inst_q    <= 32'h0;
            inst_pc_q <= 32'h0;
            fault_q   <= FAULT_NONE;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            kill_q    <= kill_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            fault_q   <= fault_d;
        end
    end

    // Handshake outputs are forced low while rst is high, even before the first clock edge.
    assign ic_araddr  = pc_q;
    assign ic_arvalid = !rst && ar_vld;
    assign ic_rready  = !rst && (state_q == S_WAIT_R);
    assign inst_valid = !rst && (state_q == S_OUT);
    assign inst       = rst ? 32'h0 : inst_q;
    assign inst_pc    = rst ? 32'h0 : inst_pc_q;
    assign inst_fault = rst ? FAULT_NONE : fault_q;
    assign ic_fence_i = fence_i;

endmodule

// File: tb/tb_ifu_fetch_stage.sv
`timescale 1ns/1ps
module tb_ifu_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h3000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] ic_araddr;
    logic        ic_arvalid;
    logic        ic_arready;
    logic [31:0] ic_rdata;
    logic [1:0]  ic_rresp;
    logic        ic_rvalid;
    logic        ic_rready;
    logic        fence_i;
    logic        ic_fence_i;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [1:0]  inst_fault;

    ifu_fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst),
        .ic_araddr(ic_araddr), .ic_arvalid(ic_arvalid), .ic_arready(ic_arready),
        .ic_rdata(ic_rdata), .ic_rresp(ic_rresp), .ic_rvalid(ic_rvalid), .ic_rready(ic_rready),
        .fence_i(fence_i), .ic_fence_i(ic_fence_i),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc), .inst_fault(inst_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_deliv  = 0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Cache contents: a distinct word per address; addresses with [7:2]==3F answer SLVERR.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'h0F0F};
    endfunction

    function automatic bit bad_resp(input logic [31:0] a);
        return a[7:2] == 6'h3F;
    endfunction

    // ---------------- cache model ----------------
    int unsigned dly_min    = 0;
    int unsigned dly_max    = 0;
    int unsigned ar_pct     = 100;
    bit          cache_hold = 1'b0;
    logic [31:0] ar_log[$];

    initial begin
        bit          outst;
        bit          hs_ar, hs_r, rst_s;
        logic [31:0] c_addr, addr_s;
        int unsigned cnt;
        outst = 1'b0; c_addr = 32'h0; cnt = 0;
        ic_arready = 1'b0; ic_rvalid = 1'b0; ic_rdata = 32'h0; ic_rresp = 2'b00;
        forever begin
            @(negedge clk);
            hs_ar  = ic_arvalid && ic_arready;
            hs_r   = ic_rvalid && ic_rready;
            rst_s  = rst;
            addr_s = ic_araddr;
            @(posedge clk);
            #2;
            if (rst_s) begin
                outst = 1'b0;
            end else begin
                if (hs_r) outst = 1'b0;
                if (hs_ar) begin
                    chk(!outst, "one_outstanding", 32'(outst), 32'd0);
                    outst  = 1'b1;
                    c_addr = addr_s;
                    cnt    = $urandom_range(dly_max, dly_min);
                    ar_log.push_back(addr_s);
                end
            end
            if (cache_hold) begin
                ic_arready = 1'b0;
                ic_rvalid  = 1'b1;
                ic_rdata   = 32'hDEAD_BEEF;
                ic_rresp   = 2'b00;
            end else begin
                ic_arready = !outst && ($urandom_range(99, 0) < ar_pct);
                ic_rvalid  = outst && (cnt == 0);
                ic_rdata   = outst ? mem_word(c_addr) : 32'hBAD0_0000;
                ic_rresp   = (outst && bad_resp(c_addr)) ? 2'b10 : 2'b00;
                if (outst && cnt > 0) cnt--;
            end
        end
    end

    // ---------------- reference model + monitor ----------------
    // Architectural view: the next instruction decode should see is at exp_q's head.
    // Reset loads RESET_PC, a redirect replaces it, an accepted instruction advances it by 4.
    logic [31:0] exp_q[$];

    initial begin
        bit          p_hold;
        logic [31:0] p_inst, p_pc, e, ei;
        logic [1:0]  p_f, ef;
        p_hold = 1'b0; p_inst = 0; p_pc = 0; p_f = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk(!ic_arvalid && !ic_rready && !inst_valid && inst == 0 && inst_pc == 0 && inst_fault == 0,
                    "reset_outputs", {ic_arvalid, ic_rready, inst_valid, inst_fault, 27'(inst_pc != 0)}, 32'd0);
                exp_q.delete();
                exp_q.push_back(RST_PC);
                p_hold = 1'b0;
            end else begin
                if (p_hold)
                    chk(inst_valid && inst == p_inst && inst_pc == p_pc && inst_fault == p_f,
                        "hold_stable", inst_pc, p_pc);
                if (ic_araddr[1:0] != 2'b00)
                    chk(!ic_arvalid, "no_arvalid_misaligned", 32'(ic_arvalid), 32'd0);
                p_hold = inst_valid && !inst_ready && !redirect_valid;
                p_inst = inst; p_pc = inst_pc; p_f = inst_fault;
                if (redirect_valid) begin
                    exp_q.delete();
                    exp_q.push_back(redirect_pc);
                end else if (inst_valid && inst_ready) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_inst", inst_pc, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        if (e[1:0] != 2'b00) begin
                            ei = 32'h0; ef = 2'b10;
                        end else begin
                            ei = mem_word(e); ef = bad_resp(e) ? 2'b01 : 2'b00;
                        end
                        chk(inst_pc == e, "inst_pc", inst_pc, e);
                        chk(inst == ei && inst_fault == ef, "inst_data", inst ^ 32'(inst_fault), ei ^ 32'(ef));
                        exp_q.push_back(e + 32'd4);
                        n_deliv++;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sig(input bit want_rready, input string name);
        int i;
        for (i = 0; i < 200; i++) begin
            if (want_rready ? ic_rready : inst_valid) break;
            cyc();
        end
        chk(i < 200, name, 32'(i), 32'd200);
    endtask

    initial begin
        logic [31:0] pc0, t;
        bit found;
        rst = 1'b1; fence_i = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;

        // Reset release with an always-hitting cache and decode always ready.
        dly_min = 0; dly_max = 0; ar_pct = 100; inst_ready = 1'b1;
        repeat (3) cyc();
        ar_log.delete();
        rst = 1'b0;
        chk(ic_araddr == RST_PC, "first_araddr", ic_araddr, RST_PC);
        repeat (14) cyc();
        chk(ar_log.size() >= 3, "hit_ar_count", 32'(ar_log.size()), 32'd3);
        if (ar_log.size() >= 3) begin
            chk(ar_log[0] == RST_PC,         "hit_ar0", ar_log[0], RST_PC);
            chk(ar_log[1] == RST_PC + 32'd4, "hit_ar1", ar_log[1], RST_PC + 32'd4);
            chk(ar_log[2] == RST_PC + 32'd8, "hit_ar2", ar_log[2], RST_PC + 32'd8);
        end
        fence_i = 1'b1; #1;
        chk(ic_fence_i == 1'b1, "fence_pass_1", 32'(ic_fence_i), 32'd1);
        fence_i = 1'b0; #1;
        chk(ic_fence_i == 1'b0, "fence_pass_0", 32'(ic_fence_i), 32'd0);

        // Miss with 5-cycle response, decode stalls 3 cycles.
        inst_ready = 1'b0; dly_min = 5; dly_max = 5;
        wait_sig(1'b0, "miss_wait_valid");
        pc0 = inst_pc;
        chk(ic_araddr == pc0, "pc_before_hs", ic_araddr, pc0);
        repeat (3) cyc();
        chk(ic_araddr == pc0 && inst_pc == pc0 && inst_valid, "pc_held", ic_araddr, pc0);
        inst_ready = 1'b1;
        cyc();
        inst_ready = 1'b0;
        chk(ic_araddr == pc0 + 32'd4, "pc_after_hs", ic_araddr, pc0 + 32'd4);
        chk(!inst_valid, "valid_drop_after_hs", 32'(inst_valid), 32'd0);

        // Redirect while the read is outstanding: stale data must never reach decode.
        wait_sig(1'b1, "wait_rready");
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0010;
        cyc();
        redirect_valid = 1'b0;
        chk(ic_araddr == 32'h8000_0010, "redirect_araddr", ic_araddr, 32'h8000_0010);
        wait_sig(1'b0, "redir_wait_valid");
        chk(inst_pc == 32'h8000_0010 && inst == mem_word(32'h8000_0010), "redir_first_inst", inst_pc, 32'h8000_0010);

        // Redirect in OUT together with inst_ready: buffer dropped, fetch at target.
        dly_min = 0; dly_max = 2;
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0100; inst_ready = 1'b1;
        cyc();
        redirect_valid = 1'b0; inst_ready = 1'b0;
        chk(!inst_valid, "redir_out_drop", 32'(inst_valid), 32'd0);
        chk(ic_araddr == 32'h8000_0100, "redir_out_araddr", ic_araddr, 32'h8000_0100);
        wait_sig(1'b0, "redir_out_wait");
        chk(inst_pc == 32'h8000_0100, "redir_out_inst_pc", inst_pc, 32'h8000_0100);

        // Misaligned target: no bus request, fault 10.
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0002;
        cyc();
        redirect_valid = 1'b0;
        chk(!ic_arvalid, "misaligned_no_ar", 32'(ic_arvalid), 32'd0);
        cyc();
        chk(inst_valid && inst_fault == 2'b10 && inst_pc == 32'h8000_0002 && inst == 32'h0,
            "misaligned_fault", {inst_fault, inst_pc[29:0]}, {2'b10, 30'h0000_0002});

        // Error response: fault 01.
        redirect_valid = 1'b1; redirect_pc = 32'h8000_00FC;
        cyc();
        redirect_valid = 1'b0;
        wait_sig(1'b0, "slverr_wait");
        chk(inst_fault == 2'b01 && inst_pc == 32'h8000_00FC, "access_fault", 32'(inst_fault), 32'd1);

        // PC wrap at the top of the address space.
        ar_log.delete();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; inst_ready = 1'b1;
        cyc();
        redirect_valid = 1'b0;
        repeat (30) cyc();
        found = 1'b0;
        foreach (ar_log[k]) if (ar_log[k] == 32'h0) found = 1'b1;
        chk(found, "pc_wrap_fetch0", 32'(found), 32'd1);

        // Reset while waiting for data; a late rvalid is ignored.
        inst_ready = 1'b0; dly_min = 5; dly_max = 5;
        wait_sig(1'b1, "rst_wait_rready");
        rst = 1'b1; cache_hold = 1'b1;
        cyc();
        rst = 1'b0;
        chk(ic_araddr == RST_PC && !inst_valid && !ic_rready, "rst_mid_wait", ic_araddr, RST_PC);
        cyc();
        chk(!ic_rready && ic_rvalid && !inst_valid, "late_rvalid_ignored", {30'h0, ic_rready, inst_valid}, 32'd0);
        cyc();
        cache_hold = 1'b0; dly_min = 0; dly_max = 3;
        wait_sig(1'b0, "rst_wait_valid");
        chk(inst_pc == RST_PC && inst == mem_word(RST_PC), "post_rst_inst", inst, mem_word(RST_PC));

        // Randomised traffic.
        ar_pct = 70; dly_min = 0; dly_max = 4;
        for (int c = 0; c < 3000; c++) begin
            inst_ready = ($urandom_range(3, 0) != 0);
            rst = ($urandom_range(399, 0) == 0);
            if ($urandom_range(24, 0) == 0) begin
                t = $urandom();
                case ($urandom_range(9, 0))
                    0:       t[1:0] = 2'($urandom_range(3, 1));
                    1:       t = 32'hFFFF_FFF8;
                    default: t[1:0] = 2'b00;
                endcase
                redirect_valid = 1'b1; redirect_pc = t;
            end else begin
                redirect_valid = 1'b0;
            end
            cyc();
        end
        rst = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0;
        repeat (2) cyc();
        chk(n_deliv > 200, "delivery_count", 32'(n_deliv), 32'd200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
